// File: rtl/rgf_pkg.sv
// rgf_pkg: shared types and default sizes for the rgf_mp multi-port register file.
package rgf_pkg;

  localparam int RGF_XLEN  = 32;
  localparam int RGF_NREGS = 32;
  localparam int RGF_NRD   = 2;

  typedef enum logic [0:0] {
    RGF_CLR = 1'b0,
    RGF_RUN = 1'b1
  } rgf_state_e;

  // Width of a bus that packs nports fields of width bits each.
  function automatic int rgf_bus_w(input int nports, input int width);
    return nports * width;
  endfunction

endpackage

// File: rtl/rgf_scoreboard.sv
// rgf_scoreboard: per-register busy bits for issue; a mark beats a same-cycle
// writeback clear of the same register, and x0 is never busy.
module rgf_scoreboard
  import rgf_pkg::*;
#(
  parameter int NREGS = RGF_NREGS,
  parameter int NRD   = RGF_NRD,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        set_vld,
  input  logic [AW-1:0]               set_idx,
  input  logic                        clr_vld,
  input  logic [AW-1:0]               clr_idx,
  input  logic [rgf_bus_w(NRD,AW)-1:0] rn,
  output logic [NRD-1:0]              rdy
);

  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [AW-1:0]    look_idx_s;

  // Next busy vector: clear first so that a mark on the same register wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (clr_vld) begin
      busy_nxt_s[clr_idx] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (set_vld && (set_idx != IDX_ZERO)) begin
      busy_nxt_s[set_idx] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Per-port ready lookup.
  always_comb begin
    rdy        = {NRD{1'b0}};
    look_idx_s = IDX_ZERO;
    for (int k = 0; k < NRD; k++) begin
      look_idx_s = rn[k*AW +: AW];
      rdy[k]     = (look_idx_s == IDX_ZERO) | ~busy_r[look_idx_s];
    end
  end

endmodule

// File: rtl/rgf_mp.sv
// rgf_mp: NRD-read / 1-write integer register file with busy scoreboard and a
// post-reset clear sequence. Define RGF_BYPASS_EN for same-cycle write forwarding.
module rgf_mp
  import rgf_pkg::*;
#(
  parameter int XLEN  = RGF_XLEN,
  parameter int NREGS = RGF_NREGS,
  parameter int NRD   = RGF_NRD,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [rgf_bus_w(NRD,AW)-1:0]   rn,
  output logic [rgf_bus_w(NRD,XLEN)-1:0] rdata,
  output logic [NRD-1:0]                rrdy,
  input  logic                          we,
  input  logic [AW-1:0]                 wn,
  input  logic [XLEN-1:0]               wdata,
  input  logic                          mark_vld,
  input  logic [AW-1:0]                 mark_rd,
  output logic                          ready
);

  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NREGS - 1);

  rgf_state_e      state_r;
  rgf_state_e      state_nxt_s;
  logic [AW-1:0]   idx_r;
  logic [AW-1:0]   idx_nxt_s;
  logic            ready_r;
  logic            run_s;

  logic [XLEN-1:0] regs_r [NREGS];
  logic            wr_en_s;
  logic [AW-1:0]   wr_idx_s;
  logic [XLEN-1:0] wr_data_s;
  logic            wr_run_s;
  logic            mark_run_s;
  logic            byp_mark_s;
  logic [NRD-1:0]  byp_hit_s;
  logic [NRD-1:0]  sb_rdy_s;
  logic [AW-1:0]   rd_idx_s;

  assign run_s      = (state_r == RGF_RUN);
  assign wr_run_s   = run_s && we && (wn != IDX_ZERO);
  assign mark_run_s = run_s && mark_vld && (mark_rd != IDX_ZERO);
  assign byp_mark_s = mark_vld && (mark_rd == wn);
  assign ready      = ready_r;

  // Clear sequencer: walk idx from 1 to NREGS-1, then stay in RUN.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      RGF_CLR: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = RGF_RUN;
        end else begin
          idx_nxt_s = idx_r + IDX_ONE;
        end
      end
      RGF_RUN: begin
        state_nxt_s = RGF_RUN;
      end
      default: begin
        state_nxt_s = RGF_CLR;
        idx_nxt_s   = IDX_ONE;
      end
    endcase
  end

  // State, clear index and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RGF_CLR;
      idx_r   <= IDX_ONE;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      ready_r <= (state_nxt_s == RGF_RUN);
    end
  end

  // Array write port: clear sequence owns it until RUN; x0 writes are dropped.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = IDX_ZERO;
    wr_data_s = {XLEN{1'b0}};
    if (!run_s) begin
      wr_en_s  = 1'b1;
      wr_idx_s = idx_r;
    end else if (wr_run_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = wn;
      wr_data_s = wdata;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register array storage (contents undefined until the clear completes).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      regs_r[wr_idx_s] <= wr_data_s;
    end
  end

  rgf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_vld (mark_run_s),
    .set_idx (mark_rd),
    .clr_vld (wr_run_s),
    .clr_idx (wn),
    .rn      (rn),
    .rdy     (sb_rdy_s)
  );

  // Forwarding hit per read port.
  always_comb begin
    byp_hit_s = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
`ifdef RGF_BYPASS_EN
      byp_hit_s[k] = wr_run_s && (wn == rn[k*AW +: AW]);
`else
      byp_hit_s[k] = 1'b0;
`endif
    end
  end

  // Combinational read ports.
  always_comb begin
    rdata    = {rgf_bus_w(NRD, XLEN){1'b0}};
    rrdy     = {NRD{1'b0}};
    rd_idx_s = IDX_ZERO;
    for (int k = 0; k < NRD; k++) begin
      rd_idx_s = rn[k*AW +: AW];
      if (!run_s) begin
        rdata[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rrdy[k]               = 1'b0;
      end else if (byp_hit_s[k]) begin
        rdata[k*XLEN +: XLEN] = wdata;
        rrdy[k]               = ~byp_mark_s;
      end else if (rd_idx_s == IDX_ZERO) begin
        rdata[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rrdy[k]               = 1'b1;
      end else begin
        rdata[k*XLEN +: XLEN] = regs_r[rd_idx_s];
        rrdy[k]               = sb_rdy_s[k];
      end
    end
  end

endmodule

// File: tb/tb_rgf_mp.sv
// tb_rgf_mp: randomized and directed checks of rgf_mp against a register/busy
// array model; a second instance covers the 16x64, 4-read-port configuration.
module tb_rgf_mp;

  localparam int XL  = 32;
  localparam int NR  = 32;
  localparam int ND  = 2;
  localparam int AW  = 5;
  localparam int XL4 = 64;
  localparam int NR4 = 16;
  localparam int ND4 = 4;
  localparam int AW4 = 4;
`ifdef RGF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [ND*AW-1:0] rn = '0;
  logic [ND*XL-1:0] rdata;
  logic [ND-1:0]    rrdy;
  logic             we = 1'b0;
  logic [AW-1:0]    wn = '0;
  logic [XL-1:0]    wdata = '0;
  logic             mark_vld = 1'b0;
  logic [AW-1:0]    mark_rd = '0;
  logic             ready;

  logic [ND4*AW4-1:0] rn4 = '0;
  logic [ND4*XL4-1:0] rdata4;
  logic [ND4-1:0]     rrdy4;
  logic               we4 = 1'b0;
  logic [AW4-1:0]     wn4 = '0;
  logic [XL4-1:0]     wdata4 = '0;
  logic               mark_vld4 = 1'b0;
  logic [AW4-1:0]     mark_rd4 = '0;
  logic               ready4;

  int vectors = 0;
  int miscompares = 0;

  logic [XL-1:0] m_regs [NR];
  bit            m_busy [NR];
  int            m_edges = 0;

  always #5 clk = ~clk;

  rgf_mp dut (
    .clk(clk), .rst_n(rst_n), .rn(rn), .rdata(rdata), .rrdy(rrdy),
    .we(we), .wn(wn), .wdata(wdata), .mark_vld(mark_vld), .mark_rd(mark_rd),
    .ready(ready)
  );

  rgf_mp #(.XLEN(XL4), .NREGS(NR4), .NRD(ND4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rn(rn4), .rdata(rdata4), .rrdy(rrdy4),
    .we(we4), .wn(wn4), .wdata(wdata4), .mark_vld(mark_vld4), .mark_rd(mark_rd4),
    .ready(ready4)
  );

  function automatic bit m_ready();
    return m_edges >= NR - 1;
  endfunction

  // Expected outputs for the current inputs from the model state.
  function automatic void predict(output logic e_ready, output logic [ND-1:0] e_rrdy,
                                  output logic [ND*XL-1:0] e_rdata);
    logic [AW-1:0] idx;
    e_ready = m_ready();
    e_rrdy  = '0;
    e_rdata = '0;
    for (int k = 0; k < ND; k++) begin
      idx = rn[k*AW +: AW];
      if (!m_ready()) begin
        e_rrdy[k] = 1'b0;
      end else if (BYP && we && wn != 0 && wn == idx) begin
        e_rdata[k*XL +: XL] = wdata;
        e_rrdy[k] = !(mark_vld && mark_rd == wn);
      end else begin
        e_rdata[k*XL +: XL] = (idx == 0) ? '0 : m_regs[idx];
        e_rrdy[k] = (idx == 0) || !m_busy[idx];
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (m_edges < NR - 1) begin
      m_edges++;
      if (m_edges == NR - 1) for (int i = 0; i < NR; i++) m_regs[i] = '0;
    end else begin
      if (we && wn != 0) begin
        m_regs[wn] = wdata;
        m_busy[wn] = 1'b0;
      end
      if (mark_vld && mark_rd != 0) m_busy[mark_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; mark_vld = 1'b0; wn = '0; mark_rd = '0; wdata = '0; rn = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (ready !== 1'b0 || rrdy !== 2'b00 || rdata !== 64'h0 || ready4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: ready=%b rrdy=%b rdata=%h ready4=%b, want 0 0 0 0",
               ready, rrdy, rdata, ready4);
    end
    m_edges = 0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic e_r; logic [ND-1:0] e_y; logic [ND*XL-1:0] e_d;
    do_reset();
    for (int i = 0; i < NR - 1; i++) begin
      rn = ND*AW'($urandom); we = $urandom_range(0, 1); wn = AW'($urandom);
      wdata = $urandom; mark_vld = $urandom_range(0, 1); mark_rd = AW'($urandom);
      #1;
      predict(e_r, e_y, e_d);
      vectors++;
      if (ready !== 1'b0 || {rrdy, rdata} !== {e_y, e_d}) begin
        miscompares++;
        $display("FAIL clear_phase cyc=%0d: ready=%b rrdy=%b rdata=%h want 0 %b %h",
                 i, ready, rrdy, rdata, e_y, e_d);
      end
      tick();
    end
    idle();
    for (int i = 0; i < NR / 2; i++) begin
      rn = {AW'(2*i + 1), AW'(2*i)};
      #1;
      vectors++;
      if (ready !== 1'b1 || rrdy !== 2'b11 || rdata !== 64'h0) begin
        miscompares++;
        $display("FAIL cleared_read x%0d/x%0d: ready=%b rrdy=%b rdata=%h want 1 11 0",
                 2*i, 2*i + 1, ready, rrdy, rdata);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    idle();
    we = 1'b1; wn = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    wn = 5'd0; wdata = 32'h00001234; rn = {5'd0, 5'd5};
    #1;
    vectors++;
    if (rdata !== {32'h0, 32'hDEADBEEF} || rrdy !== 2'b11) begin
      miscompares++;
      $display("FAIL write_x5: rdata=%h rrdy=%b want 00000000deadbeef 11", rdata, rrdy);
    end
    tick();
    idle();
    rn = {5'd5, 5'd0};
    #1;
    vectors++;
    if (rdata !== {32'hDEADBEEF, 32'h0}) begin
      miscompares++;
      $display("FAIL write_x0_dropped: rdata=%h want deadbeef00000000", rdata);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    mark_vld = 1'b1; mark_rd = 5'd7; rn = {5'd7, 5'd7};
    tick();
    mark_vld = 1'b0;
    #1;
    vectors++;
    if (rrdy !== 2'b00) begin
      miscompares++;
      $display("FAIL mark_busy: rrdy=%b want 00", rrdy);
    end
    we = 1'b1; wn = 5'd7; wdata = 32'h55;
    tick();
    we = 1'b0;
    #1;
    vectors++;
    if (rrdy !== 2'b11 || rdata !== {32'h55, 32'h55}) begin
      miscompares++;
      $display("FAIL write_clears_busy: rrdy=%b rdata=%h want 11 %h", rrdy, rdata, {32'h55, 32'h55});
    end
    we = 1'b1; wn = 5'd7; wdata = 32'h66; mark_vld = 1'b1; mark_rd = 5'd7;
    tick();
    idle(); rn = {5'd7, 5'd7};
    #1;
    vectors++;
    if (rrdy !== 2'b00 || rdata !== {32'h66, 32'h66}) begin
      miscompares++;
      $display("FAIL mark_wins: rrdy=%b rdata=%h want 00 %h", rrdy, rdata, {32'h66, 32'h66});
    end
    we = 1'b1; wn = 5'd7; wdata = 32'h77; mark_vld = 1'b1; mark_rd = 5'd8;
    tick();
    idle(); rn = {5'd8, 5'd7};
    #1;
    vectors++;
    if (rrdy !== 2'b01 || rdata[31:0] !== 32'h77) begin
      miscompares++;
      $display("FAIL mark_write_diff: rrdy=%b rdata0=%h want 01 00000077", rrdy, rdata[31:0]);
    end
    we = 1'b1; wn = 5'd8; wdata = 32'h88;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    logic [XL-1:0] old;
    logic [XL-1:0] want;
    idle();
    old = m_regs[3];
    want = BYP ? 32'hA5A5A5A5 : old;
    we = 1'b1; wn = 5'd3; wdata = 32'hA5A5A5A5; rn = {5'd3, 5'd3};
    #1;
    vectors++;
    if (rdata !== {want, want} || rrdy !== 2'b11) begin
      miscompares++;
      $display("FAIL bypass_x3: rdata=%h rrdy=%b want %h 11", rdata, rrdy, {want, want});
    end
    tick();
    wdata = 32'h5A5A5A5A; mark_vld = 1'b1; mark_rd = 5'd3; rn = {5'd0, 5'd3};
    #1;
    vectors++;
    if (rdata[31:0] !== (BYP ? 32'h5A5A5A5A : 32'hA5A5A5A5) || rrdy !== (BYP ? 2'b10 : 2'b11)) begin
      miscompares++;
      $display("FAIL bypass_mark: rdata0=%h rrdy=%b", rdata[31:0], rrdy);
    end
    tick();
    idle(); we = 1'b1; wn = 5'd3; wdata = 32'h3;
    tick();
    idle();
  endtask

  task automatic test_random();
    logic e_r; logic [ND-1:0] e_y; logic [ND*XL-1:0] e_d;
    for (int i = 0; i < 400; i++) begin
      rn = {AW'($urandom), AW'($urandom)};
      if ($urandom_range(0, 3) == 0) rn[AW-1:0] = wn;
      we = ($urandom_range(0, 1) == 1); wn = AW'($urandom); wdata = $urandom;
      mark_vld = ($urandom_range(0, 3) == 0); mark_rd = AW'($urandom);
      if ($urandom_range(0, 3) == 0) rn[2*AW-1:AW] = wn;
      #1;
      predict(e_r, e_y, e_d);
      vectors++;
      if ({ready, rrdy, rdata} !== {e_r, e_y, e_d}) begin
        miscompares++;
        $display("FAIL random cyc=%0d: ready=%b rrdy=%b rdata=%h want %b %b %h",
                 i, ready, rrdy, rdata, e_r, e_y, e_d);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    do_reset();
    for (int i = 0; i < NR - 1; i++) begin
      #1;
      vectors++;
      if (ready !== 1'b0) begin
        miscompares++;
        $display("FAIL restart_clear cyc=%0d: ready=%b want 0", i, ready);
      end
      tick();
    end
    mark_vld = 1'b1; mark_rd = 5'd9; rn = {5'd9, 5'd9};
    #1;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_latency: ready=%b want 1", ready);
    end
    tick();
    mark_vld = 1'b0;
    #1;
    vectors++;
    if (rrdy !== 2'b00) begin
      miscompares++;
      $display("FAIL x9_busy: rrdy=%b want 00", rrdy);
    end
    do_reset();
    for (int i = 0; i < NR - 1; i++) tick();
    #1;
    vectors++;
    if (ready !== 1'b1 || rrdy !== 2'b11 || rdata !== 64'h0) begin
      miscompares++;
      $display("FAIL run_reset_x9: ready=%b rrdy=%b rdata=%h want 1 11 0", ready, rrdy, rdata);
    end
    idle();
  endtask

  task automatic test_wide();
    logic [XL4-1:0] m4 [NR4];
    logic [AW4-1:0] pick [ND4];
    bit used;
    int got4;
    idle();
    do_reset();
    got4 = -1;
    for (int i = 0; i < 100 && got4 < 0; i++) begin
      #1;
      if (ready4 === 1'b1) got4 = i;
      else tick();
    end
    vectors++;
    if (got4 != NR4 - 1) begin
      miscompares++;
      $display("FAIL wide_clear_latency: ready after %0d edges, want %0d", got4, NR4 - 1);
    end
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < ND4; p++) begin
        do begin
          pick[p] = AW4'($urandom_range(1, NR4 - 1));
          used = 1'b0;
          for (int q = 0; q < p; q++) if (pick[q] == pick[p]) used = 1'b1;
        end while (used);
        we4 = 1'b1; wn4 = pick[p]; wdata4 = {$urandom, $urandom};
        m4[pick[p]] = wdata4;
        tick();
      end
      we4 = 1'b0;
      rn4 = {pick[3], pick[2], pick[1], pick[0]};
      #1;
      for (int p = 0; p < ND4; p++) begin
        vectors++;
        if (rdata4[p*XL4 +: XL4] !== m4[pick[p]] || rrdy4[p] !== 1'b1) begin
          miscompares++;
          $display("FAIL wide_read r%0d p%0d x%0d: rdata=%h rrdy=%b want %h 1",
                   r, p, pick[p], rdata4[p*XL4 +: XL4], rrdy4[p], m4[pick[p]]);
        end
      end
      tick();
    end
    rn4 = '0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_random();
    test_reset_mid();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
